// File: rtl/raw_timing_ctrl.sv
// Camera raw-pixel timing front end: frames vsync/href into counted, validated pixels.
// Optional window crop is enabled by defining RAW_TIMING_CROP_EN.
module raw_timing_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int CROP_X0   = 0,
  parameter int CROP_Y0   = 0
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iVSYNC,
  input  logic                 iHREF,
  input  logic [DATA_SIZE-1:0] iDATA,
  input  logic                 iEN,
  output logic [DATA_SIZE-1:0] oDATA,
  output logic                 oDVAL,
  output logic [15:0]          oX_Cont,
  output logic [15:0]          oY_Cont,
  output logic                 oFrame_Start,
  output logic                 oFrame_Err,
  output logic [15:0]          oFrame_Cnt
);

  // state  | meaning
  // IDLE   | capture disabled, waiting for iEN
  // SYNC   | armed, waiting for the end of vertical blank
  // ACTIVE | counting lines and pixels of the current frame
  // DRAIN  | all lines received, waiting for the next vertical blank
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DRAIN} stateT;

`ifdef RAW_TIMING_CROP_EN
  localparam logic [16:0] X0 = 17'(CROP_X0);
  localparam logic [16:0] Y0 = 17'(CROP_Y0);
`else
  // Origin fixed at 0,0; the crop parameters have no effect in this build.
  localparam logic [16:0] X0 = 17'(0 * CROP_X0);
  localparam logic [16:0] Y0 = 17'(0 * CROP_Y0);
`endif
  localparam logic [16:0] XEND = X0 + 17'(H_ACTIVE);
  localparam logic [16:0] YEND = Y0 + 17'(V_ACTIVE);

  stateT       state;
  logic        vsR;
  logic        hrefR;
  logic [15:0] colCnt;
  logic [15:0] lineCnt;
  logic        firstPend;

  logic        vsRise;
  logic        vsFall;
  logic        hrefFall;
  logic [16:0] colExt;
  logic [16:0] lineExt;
  logic [16:0] lineNext;
  logic        inWin;
  logic        overCol;
  logic        shortLine;
  logic        lineClosing;
  logic [16:0] linesAtEnd;

  always_comb begin
    vsRise      = iVSYNC & ~vsR;
    vsFall      = ~iVSYNC & vsR;
    hrefFall    = ~iHREF & hrefR;
    colExt      = {1'b0, colCnt};
    lineExt     = {1'b0, lineCnt};
    lineNext    = lineExt + 17'd1;
    inWin       = (colExt >= X0) && (colExt < XEND) &&
                  (lineExt >= Y0) && (lineExt < YEND);
    overCol     = colExt >= XEND;
    shortLine   = colExt < XEND;
    // A vsync edge that lands on an open (or just-closed) line ends that line too.
    lineClosing = iHREF | hrefFall;
    linesAtEnd  = lineClosing ? lineNext : lineExt;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= IDLE;
      vsR          <= 1'b0;
      hrefR        <= 1'b0;
      colCnt       <= 16'd0;
      lineCnt      <= 16'd0;
      firstPend    <= 1'b0;
      oDATA        <= '0;
      oDVAL        <= 1'b0;
      oX_Cont      <= 16'd0;
      oY_Cont      <= 16'd0;
      oFrame_Start <= 1'b0;
      oFrame_Err   <= 1'b0;
      oFrame_Cnt   <= 16'd0;
    end else begin
      vsR          <= iVSYNC;
      hrefR        <= iHREF;
      oDVAL        <= 1'b0;
      oFrame_Start <= 1'b0;

      unique case (state)
        IDLE: begin
          if (iEN) state <= SYNC;
        end

        SYNC: begin
          if (vsFall) begin
            state      <= ACTIVE;
            colCnt     <= 16'd0;
            lineCnt    <= 16'd0;
            oFrame_Err <= 1'b0;
            firstPend  <= 1'b1;
          end
        end

        ACTIVE: begin
          if (vsRise) begin
            if (lineClosing && shortLine) oFrame_Err <= 1'b1;
            if (linesAtEnd < YEND) oFrame_Err <= 1'b1;
            else                   oFrame_Cnt <= oFrame_Cnt + 16'd1;
            colCnt    <= 16'd0;
            firstPend <= 1'b0;
            state     <= iEN ? SYNC : IDLE;
          end else if (hrefFall) begin
            if (shortLine) oFrame_Err <= 1'b1;
            colCnt  <= 16'd0;
            lineCnt <= lineCnt + 16'd1;
            if (lineNext >= YEND) state <= DRAIN;
          end else if (iHREF) begin
            if (colCnt != 16'hFFFF) colCnt <= colCnt + 16'd1;
            if (inWin) begin
              oDVAL        <= 1'b1;
              oDATA        <= iDATA;
              oX_Cont      <= 16'(colExt - X0);
              oY_Cont      <= 16'(lineExt - Y0);
              oFrame_Start <= firstPend;
              firstPend    <= 1'b0;
            end else if (overCol) begin
              oFrame_Err <= 1'b1;
            end
          end
        end

        DRAIN: begin
          if (vsRise) begin
            oFrame_Cnt <= oFrame_Cnt + 16'd1;
            state      <= iEN ? SYNC : IDLE;
          end else if (iHREF) begin
            // Lines beyond the frame height are dropped and flagged.
            oFrame_Err <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
